melody_sequencer: RTL and testbench
===================================

Name: melody_sequencer

Overview:
- Plays a stored melody on the buzzer path by stepping through a song ROM one entry at a time.
- For each entry it drives the 8-bit note code into the note-to-period lookup and gates the PWM with beep_en.
- Holds each note for its programmed number of beats, then inserts a short silent gap between notes.
- Sits between the top-level key/control logic and the hz lookup + PWM generator; it is the only block that sequences that datapath.

Parameters:
CLK_FRE, 50, system clock frequency in MHz
MS_CYC, CLK_FRE*1000, clock cycles per millisecond tick; overridden to a small value in simulation
BEAT_MS, 250, length of one duration unit in ms
GAP_MS, 20, silent gap after every note in ms; 0 skips the gap
SONG_LEN, 32, ROM depth in entries
ADDR_W, 5, ROM address width; must satisfy 2**ADDR_W >= SONG_LEN

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; begins playback from address 0
stop  in  1  one-cycle pulse; aborts playback
loop_en  in  1  at end of song, restart from address 0 instead of finishing
rom_addr  out  ADDR_W  song ROM address (registered)
rom_data  in  12  ROM entry {dur[11:8], note[7:0]}; synchronous ROM, 1-cycle read latency
hz_sel  out  8  note code to the hz lookup; 8'h00 while silent
beep_en  out  1  PWM enable
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on normal song completion

Behaviour:
- Reset:
  - Clock is sys_clk. Reset is sys_rst, synchronous and active-high, and has priority over all other inputs.
  - On reset, state = IDLE and rom_addr, hz_sel, beep_en, busy, done all = 0. The ms and beat counters clear.
- States: IDLE, FETCH, LOAD, PLAY, GAP, DONE.
- IDLE:
  - start=1 and stop=0: rom_addr <= 0, go to FETCH.
  - start and stop asserted in the same cycle: stop wins, remain in IDLE.
- FETCH: one cycle, waiting for the ROM to register its data. Go to LOAD.
- LOAD: sample rom_data. The sample is taken 2 cycles after rom_addr changes.
  - dur == 0 is the end-of-song marker:
    - loop_en=1: rom_addr <= 0, go to FETCH.
    - loop_en=0: go to DONE.
  - Otherwise: hz_sel <= note, beep_en <= (note != 8'h00), and load the beat target = dur*BEAT_MS ms. Go to PLAY.
  - note 8'h00 with a nonzero dur is a rest: timed silence with beep_en=0.
- PLAY:
  - The ms counter counts MS_CYC cycles per tick. The beat counter counts ticks.
  - When the tick count reaches dur*BEAT_MS: clear hz_sel and beep_en.
    - GAP_MS > 0: go to GAP.
    - GAP_MS = 0: take the advance step directly.
  - PLAY therefore lasts exactly dur*BEAT_MS*MS_CYC cycles.
- GAP: hz_sel=0, beep_en=0 for GAP_MS*MS_CYC cycles, then take the advance step.
- Advance step:
  - rom_addr == SONG_LEN-1: treat as end of song (same loop_en rule as the dur==0 marker).
  - Otherwise: rom_addr <= rom_addr+1, go to FETCH.
- DONE: done=1 for one cycle, then go to IDLE. busy is high in DONE and drops in the following cycle.
- stop in any non-IDLE state: next cycle state = IDLE with hz_sel=0, beep_en=0, busy=0, counters cleared. done is not pulsed.
- start while busy: ignored.
- loop_en is sampled only at end of song. Changing it mid-note has no effect until then.
- Width rules:
  - ms counter width = clog2(MS_CYC).
  - Beat/tick counter width = clog2(15*BEAT_MS+1).
  - GAP shares the tick counter with PLAY.
  - All products are computed at elaboration time; no runtime multiplier is needed beyond dur*BEAT_MS.
- Outputs hz_sel, beep_en and rom_addr are registered and glitch-free.

Decomposition:
- Shared package:
  - State encoding.
  - ROM field positions: DUR_MSB=11, DUR_LSB=8, NOTE_MSB=7, NOTE_LSB=0.
  - NOTE_REST = 8'h00.
  - END_DUR = 4'd0.
  - Note-code constants for low/middle/high/super-high 1–7 (8'h01–8'h37, same coding as the hz lookup).
- Sub-module ms_tick_gen:
  - Free-running divider producing a one-cycle tick every MS_CYC cycles.
  - Has a clear input, driven on every state entry so that note lengths are exact.

Test Plan (MS_CYC=4, BEAT_MS=2, GAP_MS=1, SONG_LEN=8):
1. ROM {3,8'h11},{0,x}, loop_en=0; pulse start -> rom_addr=0 then LOAD 2 cycles later; hz_sel=8'h11, beep_en=1 for exactly 24 cycles; then 4 gap cycles with beep_en=0; then done pulse one cycle; busy=0 after.
2. ROM {1,8'h00},{2,8'h25},{0,x} -> first 8 cycles hz_sel=0, beep_en=0 (rest); then hz_sel=8'h25 for 16 cycles; then done.
3. Same ROM as 1 with loop_en=1 -> after gap, rom_addr returns to 0 and 8'h11 replays; no done pulse; stop pulse then IDLE next cycle, beep_en=0, no done.
4. All 8 entries nonzero dur=1 -> rom_addr walks 0..7 and finishes after entry 7 without reading address 8; done pulses once.
5. Pulse start mid-PLAY -> ignored, timing unchanged; start and stop together in IDLE -> stays IDLE, busy=0.
6. Assert sys_rst during PLAY -> next cycle all outputs 0 and state IDLE; a later start replays from address 0 with full 24-cycle note.

Source files
------------

// File: rtl/melody_sequencer_pkg.sv
// Shared types and constants for the melody sequencer: FSM encoding, song ROM
// field layout and note codes matching the hz lookup.
package melody_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StPlay,
    StGap,
    StDone
  } state_e;

  localparam int unsigned DUR_MSB  = 11;
  localparam int unsigned DUR_LSB  = 8;
  localparam int unsigned NOTE_MSB = 7;
  localparam int unsigned NOTE_LSB = 0;

  localparam logic [7:0] NOTE_REST = 8'h00;
  localparam logic [3:0] END_DUR   = 4'd0;

  // Low octave
  localparam logic [7:0] NOTE_L1 = 8'h01;
  localparam logic [7:0] NOTE_L2 = 8'h02;
  localparam logic [7:0] NOTE_L3 = 8'h03;
  localparam logic [7:0] NOTE_L4 = 8'h04;
  localparam logic [7:0] NOTE_L5 = 8'h05;
  localparam logic [7:0] NOTE_L6 = 8'h06;
  localparam logic [7:0] NOTE_L7 = 8'h07;
  // Middle octave
  localparam logic [7:0] NOTE_M1 = 8'h11;
  localparam logic [7:0] NOTE_M2 = 8'h12;
  localparam logic [7:0] NOTE_M3 = 8'h13;
  localparam logic [7:0] NOTE_M4 = 8'h14;
  localparam logic [7:0] NOTE_M5 = 8'h15;
  localparam logic [7:0] NOTE_M6 = 8'h16;
  localparam logic [7:0] NOTE_M7 = 8'h17;
  // High octave
  localparam logic [7:0] NOTE_H1 = 8'h21;
  localparam logic [7:0] NOTE_H2 = 8'h22;
  localparam logic [7:0] NOTE_H3 = 8'h23;
  localparam logic [7:0] NOTE_H4 = 8'h24;
  localparam logic [7:0] NOTE_H5 = 8'h25;
  localparam logic [7:0] NOTE_H6 = 8'h26;
  localparam logic [7:0] NOTE_H7 = 8'h27;
  // Super-high octave
  localparam logic [7:0] NOTE_S1 = 8'h31;
  localparam logic [7:0] NOTE_S2 = 8'h32;
  localparam logic [7:0] NOTE_S3 = 8'h33;
  localparam logic [7:0] NOTE_S4 = 8'h34;
  localparam logic [7:0] NOTE_S5 = 8'h35;
  localparam logic [7:0] NOTE_S6 = 8'h36;
  localparam logic [7:0] NOTE_S7 = 8'h37;

  function automatic logic [3:0] rom_dur(input logic [11:0] entry);
    return entry[DUR_MSB:DUR_LSB];
  endfunction

  function automatic logic [7:0] rom_note(input logic [11:0] entry);
    return entry[NOTE_MSB:NOTE_LSB];
  endfunction

endpackage

// File: rtl/melody_sequencer_ms_tick_gen.sv
// Millisecond tick divider: one-cycle tick every MS_CYC cycles, restartable
// via clear_i so the first tick after a clear lands exactly MS_CYC cycles later.
module ms_tick_gen #(
  parameter int unsigned MS_CYC = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CntW = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MS_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through a song ROM, driving note codes to the hz lookup and gating the
// PWM for each note's beat count, with an optional silent gap between notes.
module melody_sequencer
  import melody_sequencer_pkg::*;
#(
  parameter int unsigned CLK_FRE  = 50,
  parameter int unsigned MS_CYC   = CLK_FRE * 1000,
  parameter int unsigned BEAT_MS  = 250,
  parameter int unsigned GAP_MS   = 20,
  parameter int unsigned SONG_LEN = 32,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [7:0]        hz_sel,
  output logic              beep_en,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BeatW = $clog2(15 * BEAT_MS + 1);
  localparam logic [BeatW-1:0] BeatUnit = BeatW'(BEAT_MS);
  localparam logic [BeatW-1:0] GapLast  = BeatW'((GAP_MS > 0) ? GAP_MS - 1 : 0);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(SONG_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]        hz_sel_q, hz_sel_d;
  logic              beep_en_q, beep_en_d;
  logic [BeatW-1:0]  target_q, target_d;
  logic [BeatW-1:0]  beat_q, beat_d;

  logic              tick;
  logic              clear;
  logic [3:0]        dur;
  logic [7:0]        note;
  state_e            eos_state;
  logic [ADDR_W-1:0] eos_addr;
  state_e            adv_state;
  logic [ADDR_W-1:0] adv_addr;

  assign dur  = rom_dur(rom_data);
  assign note = rom_note(rom_data);

  // Every state change restarts both the ms divider and the tick counter.
  assign clear = (state_d != state_q);

  ms_tick_gen #(
    .MS_CYC (MS_CYC)
  ) u_ms_tick_gen (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .clear_i (clear),
    .tick_o  (tick)
  );

  always_comb begin
    eos_state = loop_en ? StFetch : StDone;
    eos_addr  = loop_en ? '0 : rom_addr_q;
    if (rom_addr_q == LastAddr) begin
      adv_state = eos_state;
      adv_addr  = eos_addr;
    end else begin
      adv_state = StFetch;
      adv_addr  = rom_addr_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    hz_sel_d   = hz_sel_q;
    beep_en_d  = beep_en_q;
    target_d   = target_q;

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          rom_addr_d = '0;
          state_d    = StFetch;
        end
      end
      StFetch: begin
        state_d = StLoad;
      end
      StLoad: begin
        if (dur == END_DUR) begin
          state_d    = eos_state;
          rom_addr_d = eos_addr;
        end else begin
          hz_sel_d  = note;
          beep_en_d = (note != NOTE_REST);
          target_d  = BeatW'(dur) * BeatUnit;
          state_d   = StPlay;
        end
      end
      StPlay: begin
        if (tick && (beat_q == target_q - 1'b1)) begin
          hz_sel_d  = NOTE_REST;
          beep_en_d = 1'b0;
          if (GAP_MS > 0) begin
            state_d = StGap;
          end else begin
            state_d    = adv_state;
            rom_addr_d = adv_addr;
          end
        end
      end
      StGap: begin
        if (tick && (beat_q == GapLast)) begin
          state_d    = adv_state;
          rom_addr_d = adv_addr;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (stop && (state_q != StIdle)) begin
      state_d   = StIdle;
      hz_sel_d  = NOTE_REST;
      beep_en_d = 1'b0;
    end
  end

  always_comb begin
    beat_d = beat_q;
    if (clear) begin
      beat_d = '0;
    end else if (tick) begin
      beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      rom_addr_q <= '0;
      hz_sel_q   <= NOTE_REST;
      beep_en_q  <= 1'b0;
      target_q   <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      hz_sel_q   <= hz_sel_d;
      beep_en_q  <= beep_en_d;
      target_q   <= target_d;
      beat_q     <= beat_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign hz_sel   = hz_sel_q;
  assign beep_en  = beep_en_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a small behavioural song ROM.
module tb_melody_sequencer;

  logic        sys_clk;
  logic        sys_rst;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [3:0]  rom_addr;
  logic [11:0] rom_data;
  logic [7:0]  hz_sel;
  logic        beep_en;
  logic        busy;
  logic        done;

  logic [11:0] rom [0:15];

  int n_checks = 0;
  int n_fail   = 0;

  melody_sequencer #(
    .CLK_FRE  (50),
    .MS_CYC   (4),
    .BEAT_MS  (2),
    .GAP_MS   (1),
    .SONG_LEN (8),
    .ADDR_W   (4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .hz_sel   (hz_sel),
    .beep_en  (beep_en),
    .busy     (busy),
    .done     (done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) rom_data <= rom[rom_addr];

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 12'h000;
  endtask

  // Pulse start and advance to the first PLAY cycle (FETCH, LOAD, PLAY).
  task automatic start_play();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
  endtask

  task automatic measure_high(output int len, output logic [7:0] hz);
    hz  = hz_sel;
    len = 0;
    while (beep_en && len < 1000) begin
      len++;
      step();
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 1000) begin
      n++;
      step();
    end
  endtask

  task automatic wait_beep(output int n, output int dones);
    n     = 0;
    dones = 0;
    while (!beep_en && n < 1000) begin
      if (done) dones++;
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({rom_addr, hz_sel, beep_en, busy, done} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, want 0", {rom_addr, hz_sel, beep_en, busy, done});
    end
    sys_rst = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b, want 0", busy);
    end
  endtask

  task automatic test_single_note();
    int len, n;
    logic [7:0] hz;
    clear_rom();
    rom[0] = {4'd3, 8'h11};
    loop_en = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || rom_addr !== 4'd0 || beep_en !== 1'b0) begin
      n_fail++;
      $display("FAIL single_fetch: busy=%b addr=%0d beep=%b, want 1 0 0", busy, rom_addr, beep_en);
    end
    step();
    step();
    measure_high(len, hz);
    n_checks++;
    if (len !== 24 || hz !== 8'h11) begin
      n_fail++;
      $display("FAIL single_note: len=%0d hz=%h, want 24 11", len, hz);
    end
    // 4 gap cycles, FETCH of the end marker, LOAD, then DONE
    wait_done(n);
    n_checks++;
    if (n !== 6) begin
      n_fail++;
      $display("FAIL single_gap_to_done: got %0d cycles, want 6", n);
    end
    n_checks++;
    if (busy !== 1'b1 || beep_en !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done_state: busy=%b beep=%b, want 1 0", busy, beep_en);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || hz_sel !== 8'h00) begin
      n_fail++;
      $display("FAIL single_after_done: done=%b busy=%b hz=%h, want 0 0 00", done, busy, hz_sel);
    end
  endtask

  task automatic test_rest();
    int len, n, dones;
    logic [7:0] hz;
    clear_rom();
    rom[0] = {4'd1, 8'h00};
    rom[1] = {4'd2, 8'h25};
    loop_en = 1'b0;
    start_play();
    n_checks++;
    if (hz_sel !== 8'h00 || beep_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rest_silent: hz=%h beep=%b busy=%b, want 00 0 1", hz_sel, beep_en, busy);
    end
    // 8 rest + 4 gap + FETCH + LOAD
    wait_beep(n, dones);
    n_checks++;
    if (n !== 14 || dones !== 0) begin
      n_fail++;
      $display("FAIL rest_length: got %0d cycles %0d dones, want 14 0", n, dones);
    end
    measure_high(len, hz);
    n_checks++;
    if (len !== 16 || hz !== 8'h25) begin
      n_fail++;
      $display("FAIL rest_second_note: len=%0d hz=%h, want 16 25", len, hz);
    end
    wait_done(n);
    n_checks++;
    if (n !== 6) begin
      n_fail++;
      $display("FAIL rest_done: got %0d cycles, want 6", n);
    end
    step();
  endtask

  task automatic test_loop_stop();
    int len, n, dones;
    logic [7:0] hz;
    clear_rom();
    rom[0] = {4'd3, 8'h11};
    loop_en = 1'b1;
    start_play();
    measure_high(len, hz);
    // 4 gap + FETCH + LOAD(end) + FETCH + LOAD
    wait_beep(n, dones);
    n_checks++;
    if (n !== 8 || dones !== 0) begin
      n_fail++;
      $display("FAIL loop_restart: got %0d cycles %0d dones, want 8 0", n, dones);
    end
    n_checks++;
    if (rom_addr !== 4'd0 || hz_sel !== 8'h11) begin
      n_fail++;
      $display("FAIL loop_replay: addr=%0d hz=%h, want 0 11", rom_addr, hz_sel);
    end
    step();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || beep_en !== 1'b0 || hz_sel !== 8'h00 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_stop: busy=%b beep=%b hz=%h done=%b, want 0 0 00 0",
               busy, beep_en, hz_sel, done);
    end
    dones = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dones++;
      if (busy) n++;
      step();
    end
    n_checks++;
    if (dones !== 0 || n !== 0) begin
      n_fail++;
      $display("FAIL loop_stop_idle: dones=%0d busy_cycles=%0d, want 0 0", dones, n);
    end
    loop_en = 1'b0;
  endtask

  task automatic test_walk();
    logic [7:0] notes [0:7];
    int cyc, maxa, dones, idx;
    logic prev_beep;
    notes = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h21};
    clear_rom();
    for (int i = 0; i < 8; i++) rom[i] = {4'd1, notes[i]};
    rom[8] = {4'd1, 8'hEE};
    loop_en = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    maxa = 0;
    dones = 0;
    idx = 0;
    prev_beep = 1'b0;
    while (busy && cyc < 1000) begin
      cyc++;
      if (int'(rom_addr) > maxa) maxa = int'(rom_addr);
      if (done) dones++;
      if (beep_en && !prev_beep) begin
        n_checks++;
        if (idx > 7 || hz_sel !== notes[idx[2:0]]) begin
          n_fail++;
          $display("FAIL walk_note_%0d: got %h", idx, hz_sel);
        end
        idx++;
      end
      prev_beep = beep_en;
      step();
    end
    // 8 entries x (FETCH + LOAD + 8 PLAY + 4 GAP) + DONE
    n_checks++;
    if (cyc !== 113) begin
      n_fail++;
      $display("FAIL walk_busy_cycles: got %0d, want 113", cyc);
    end
    n_checks++;
    if (maxa !== 7 || dones !== 1 || idx !== 8) begin
      n_fail++;
      $display("FAIL walk_summary: maxaddr=%0d dones=%0d notes=%0d, want 7 1 8", maxa, dones, idx);
    end
  endtask

  task automatic test_start_ignored();
    int len, n;
    clear_rom();
    rom[0] = {4'd3, 8'h11};
    loop_en = 1'b0;
    start_play();
    len = 0;
    while (beep_en && len < 1000) begin
      len++;
      start = (len == 6);
      step();
    end
    start = 1'b0;
    n_checks++;
    if (len !== 24) begin
      n_fail++;
      $display("FAIL start_ignored_len: got %0d, want 24", len);
    end
    wait_done(n);
    n_checks++;
    if (n !== 6) begin
      n_fail++;
      $display("FAIL start_ignored_done: got %0d cycles, want 6", n);
    end
    step();
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || beep_en !== 1'b0) begin
      n_fail++;
      $display("FAIL start_stop_idle: busy=%b beep=%b, want 0 0", busy, beep_en);
    end
    step();
    step();
    n_checks++;
    if (busy !== 1'b0 || rom_addr !== 4'd1) begin
      n_fail++;
      $display("FAIL start_stop_stays: busy=%b addr=%0d, want 0 1", busy, rom_addr);
    end
  endtask

  task automatic test_reset_mid_play();
    int len, n, dones;
    logic [7:0] hz;
    clear_rom();
    rom[0] = {4'd1, 8'h12};
    rom[1] = {4'd3, 8'h11};
    loop_en = 1'b0;
    start_play();
    measure_high(len, hz);
    wait_beep(n, dones);
    n_checks++;
    if (rom_addr !== 4'd1 || hz_sel !== 8'h11) begin
      n_fail++;
      $display("FAIL rst_pre_state: addr=%0d hz=%h, want 1 11", rom_addr, hz_sel);
    end
    for (int i = 0; i < 5; i++) step();
    sys_rst = 1'b1;
    step();
    n_checks++;
    if ({rom_addr, hz_sel, beep_en, busy, done} !== 15'h0) begin
      n_fail++;
      $display("FAIL rst_mid_play: got %h, want 0", {rom_addr, hz_sel, beep_en, busy, done});
    end
    sys_rst = 1'b0;
    step();
    start_play();
    measure_high(len, hz);
    n_checks++;
    if (len !== 8 || hz !== 8'h12) begin
      n_fail++;
      $display("FAIL rst_replay_first: len=%0d hz=%h, want 8 12", len, hz);
    end
    wait_beep(n, dones);
    measure_high(len, hz);
    n_checks++;
    if (len !== 24 || hz !== 8'h11) begin
      n_fail++;
      $display("FAIL rst_replay_full: len=%0d hz=%h, want 24 11", len, hz);
    end
    wait_done(n);
    n_checks++;
    if (n !== 6) begin
      n_fail++;
      $display("FAIL rst_replay_done: got %0d cycles, want 6", n);
    end
    step();
  endtask

  initial begin
    sys_rst = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    loop_en = 1'b0;
    clear_rom();
    step();
    test_reset();
    test_single_note();
    test_rest();
    test_loop_stop();
    test_walk();
    test_start_ignored();
    test_reset_mid_play();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
